seq_alu: RTL and testbench

- Parametrised, handshaked successor to the combinational 16-bit ALU.
- Single-cycle ops are registered with 1-cycle latency.
- Multiply is iterative shift-add; divide is iterative restoring, producing quotient and remainder.
- Sits between the operand registers (ar/br) and the accumulator; the controller issues ops via valid/ready and stalls on the result handshake.

---
 rtl/alu_pkg.sv | 15 +
 rtl/seq_alu_iter.sv | 56 +++++
 rtl/seq_alu.sv | 92 +++++++++
 tb/tb_seq_alu.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and result layout shared by the sequential ALU
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam int QUOT_HALF = 0;
  localparam int REM_HALF  = 1;
endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: iterative shift-add multiply / restoring divide datapath
// ports: load latches a/b/mode (0 mul, 1 div); step advances one iteration;
//        acc is the accumulator value after the current step; lastStep marks the final one
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               load,
  input  logic               step,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               lastStep
);
  logic [2*WIDTH-1:0] x, p, mn, dn;
  logic [WIDTH-1:0] y, rn;
  logic [WIDTH:0] hi;
  logic [CNT_W-1:0] cnt;
  logic md, ge;
  always_comb begin
    hi = {x[2*WIDTH-1:WIDTH], x[WIDTH-1]};
    ge = hi >= {1'b0, y};
    rn = ge ? WIDTH'(hi - {1'b0, y}) : hi[WIDTH-1:0];
    dn = {rn, x[WIDTH-2:0], ge};
    mn = p + (y[0] ? x : '0);
    acc = md ? dn : mn;
    lastStep = cnt == CNT_W'(1);
  end
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      x <= '0;
      y <= '0;
      p <= '0;
      cnt <= '0;
      md <= 1'b0;
    end else if (load) begin
      x <= {{WIDTH{1'b0}}, a};
      y <= b;
      p <= '0;
      cnt <= CNT_W'(WIDTH);
      md <= mode;
    end else if (step && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (md) x <= dn;
      else begin
        p <= mn;
        x <= x << 1;
        y <= y >> 1;
      end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered single-cycle ops and iterative mul/div
// ports: inValid/inReady accept funcSelect, ar, br; outValid/outReady hand off
//        dataAcc with carry, zero, divZero and opError flags
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               inValid,
  output logic               inReady,
  input  logic [3:0]         funcSelect,
  input  logic [WIDTH-1:0]   ar,
  input  logic [WIDTH-1:0]   br,
  output logic               outValid,
  input  logic               outReady,
  output logic [2*WIDTH-1:0] dataAcc,
  output logic               carry,
  output logic               zero,
  output logic               divZero,
  output logic               opError
);
  state_t state, nxt;
  logic accept, step, lastStep, dz, sc, serr;
  logic [WIDTH:0] sum, dif;
  logic [WIDTH-1:0] sres;
  logic [2*WIDTH-1:0] acc;
  assign inReady = rstN & (state == IDLE);
  assign outValid = state == DONE;
  assign accept = inValid & inReady;
  assign step = state == MUL || state == DIV;
  always_comb begin
    sum = {1'b0, ar} + {1'b0, br};
    dif = {1'b0, ar} - {1'b0, br};
    dz = funcSelect == OP_DIV && br == '0;
    serr = funcSelect == 4'h0 || funcSelect > OP_SHR;
    sc = funcSelect == OP_ADD ? sum[WIDTH] : funcSelect == OP_SUB ? dif[WIDTH] : 1'b0;
    sres = funcSelect == OP_ADD ? sum[WIDTH-1:0] :
           funcSelect == OP_SUB ? dif[WIDTH-1:0] :
           funcSelect == OP_AND ? ar & br :
           funcSelect == OP_OR  ? ar | br :
           funcSelect == OP_NOT ? ~ar :
           funcSelect == OP_SHL ? ar << br :
           funcSelect == OP_SHR ? ar >> br : '0;
  end
  always_comb begin
    nxt = state;
    if (state == IDLE && accept)
      nxt = funcSelect == OP_MUL ? MUL : (funcSelect == OP_DIV && !dz) ? DIV : DONE;
    else if (step && lastStep) nxt = DONE;
    else if (state == DONE && outReady) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      dataAcc <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
      divZero <= 1'b0;
      opError <= 1'b0;
    end else if (accept && nxt == DONE) begin
      if (dz) begin
        dataAcc[REM_HALF*WIDTH +: WIDTH] <= ar;
        dataAcc[QUOT_HALF*WIDTH +: WIDTH] <= '1;
      end else dataAcc <= {{WIDTH{1'b0}}, sres};
      carry <= dz ? 1'b0 : sc;
      zero <= dz ? 1'b0 : ~|sres;
      divZero <= dz;
      opError <= dz ? 1'b0 : serr;
    end else if (step && lastStep) begin
      dataAcc <= acc;
      carry <= 1'b0;
      zero <= state == DIV ? ~|acc[QUOT_HALF*WIDTH +: WIDTH] : ~|acc;
      divZero <= 1'b0;
      opError <= 1'b0;
    end
  seq_alu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk(clk),
    .rstN(rstN),
    .load(accept && (nxt == MUL || nxt == DIV)),
    .step(step),
    .mode(funcSelect == OP_DIV),
    .a(ar),
    .b(br),
    .acc(acc),
    .lastStep(lastStep)
  );
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: vector table, random ops against an arithmetic model, backpressure and reset sequences
module tb_seq_alu;
  localparam int W = 16;
  logic clk = 1'b0, rstN = 1'b0, inValid = 1'b0, outReady = 1'b1;
  logic [3:0] funcSelect = '0;
  logic [W-1:0] ar = '0, br = '0;
  logic inReady, outValid, carry, zero, divZero, opError;
  logic [2*W-1:0] dataAcc;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [3:0] f;
    logic [15:0] a, b;
    logic [31:0] acc;
    logic c, z, dz, err;
    int lat;
  } vec_t;
  vec_t tbl[17];
  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .funcSelect(funcSelect), .ar(ar), .br(br), .outValid(outValid),
    .outReady(outReady), .dataAcc(dataAcc), .carry(carry), .zero(zero),
    .divZero(divZero), .opError(opError)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    longint unsigned ua, ub, r;
    ua = a;
    ub = b;
    r = 0;
    v.f = f; v.a = a; v.b = b;
    v.c = 0; v.dz = 0; v.err = 0; v.lat = 1;
    case (f)
      4'h1: begin r = (ua + ub) % 65536; v.c = (ua + ub) > 65535; end
      4'h2: begin r = (ua + 65536 - ub) % 65536; v.c = ua < ub; end
      4'h3: begin r = ua * ub; v.lat = 17; end
      4'h4: if (ub == 0) begin r = ua * 65536 + 65535; v.dz = 1; end
            else begin r = (ua % ub) * 65536 + ua / ub; v.lat = 17; end
      4'h5: r = ua & ub;
      4'h6: r = ua | ub;
      4'h7: r = 65535 - ua;
      4'h8: r = ub >= 16 ? 0 : (ua * (64'd1 << ub)) % 65536;
      4'h9: r = ub >= 16 ? 0 : ua / (64'd1 << ub);
      default: v.err = 1;
    endcase
    v.acc = r[31:0];
    v.z = f == 4'h3 ? r == 0 : r % 65536 == 0;
    return v;
  endfunction
  task automatic run(input vec_t e, input string nm);
    int lat, busy;
    bit ok;
    @(negedge clk);
    chk({nm, " inReady idle"}, inReady, 1);
    funcSelect = e.f; ar = e.a; br = e.b; inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    ar = W'($urandom); br = W'($urandom); funcSelect = 4'($urandom);
    lat = 0; busy = 0; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (outValid) ok = 1;
      else if (inReady) busy++;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: no outValid within 40 cycles", nm);
    end else begin
      chk({nm, " latency"}, lat, e.lat);
      chk({nm, " inReady busy"}, busy, 0);
      chk({nm, " dataAcc"}, dataAcc, e.acc);
      chk({nm, " flags c/z/dz/err"}, {carry, zero, divZero, opError}, {e.c, e.z, e.dz, e.err});
    end
    @(negedge clk);
    chk({nm, " return idle"}, {inReady, outValid}, 2'b10);
  endtask
  initial begin
    vec_t v;
    int seen;
    tbl[0]  = '{4'h1, 16'hFFFF, 16'h0001, 32'h00000000, 1, 1, 0, 0, 1};
    tbl[1]  = '{4'h2, 16'h0003, 16'h0005, 32'h0000FFFE, 1, 0, 0, 0, 1};
    tbl[2]  = '{4'h8, 16'h0001, 16'd20,   32'h00000000, 0, 1, 0, 0, 1};
    tbl[3]  = '{4'h3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 0, 0, 0, 17};
    tbl[4]  = '{4'h4, 16'd100,  16'd7,    32'h0002000E, 0, 0, 0, 0, 17};
    tbl[5]  = '{4'h4, 16'h1234, 16'h0000, 32'h1234FFFF, 0, 0, 1, 0, 1};
    tbl[6]  = '{4'h5, 16'hF0F0, 16'h0FF0, 32'h000000F0, 0, 0, 0, 0, 1};
    tbl[7]  = '{4'h6, 16'hF0F0, 16'h0FF0, 32'h0000FFF0, 0, 0, 0, 0, 1};
    tbl[8]  = '{4'h7, 16'h0000, 16'h1234, 32'h0000FFFF, 0, 0, 0, 0, 1};
    tbl[9]  = '{4'h9, 16'h8000, 16'd15,   32'h00000001, 0, 0, 0, 0, 1};
    tbl[10] = '{4'h0, 16'hA5A5, 16'h5A5A, 32'h00000000, 0, 1, 0, 1, 1};
    tbl[11] = '{4'h3, 16'h0000, 16'h1234, 32'h00000000, 0, 1, 0, 0, 17};
    tbl[12] = '{4'h4, 16'd5,    16'd7,    32'h00050000, 0, 1, 0, 0, 17};
    tbl[13] = '{4'h1, 16'h1234, 16'h4321, 32'h00005555, 0, 0, 0, 0, 1};
    tbl[14] = '{4'h8, 16'h0001, 16'd15,   32'h00008000, 0, 0, 0, 0, 1};
    tbl[15] = '{4'h2, 16'h0005, 16'h0005, 32'h00000000, 0, 1, 0, 0, 1};
    tbl[16] = '{4'h3, 16'h0100, 16'h0100, 32'h00010000, 0, 0, 0, 0, 17};
    #12;
    chk("reset outputs", {inReady, outValid, dataAcc, carry, zero, divZero, opError}, '0);
    @(negedge clk) rstN = 1'b1;
    for (int i = 0; i < 17; i++) run(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = i % 4 == 0 ? 16'($urandom_range(0, 20)) : i % 9 == 0 ? 16'h0 : 16'($urandom);
      run(model(4'($urandom_range(0, 15)), a, b), $sformatf("rnd%0d", i));
    end
    outReady = 1'b0;
    @(negedge clk);
    funcSelect = 4'h1; ar = 16'h0010; br = 16'h0020; inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    @(negedge clk);
    chk("bp first valid", outValid, 1);
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; funcSelect = 4'h3; ar = 16'($urandom); br = 16'($urandom);
      @(negedge clk);
      chk("bp hold", {outValid, inReady, dataAcc, carry, zero, divZero, opError}, {2'b10, 32'h30, 4'b0000});
    end
    inValid = 1'b0; outReady = 1'b1;
    @(negedge clk);
    chk("bp release idle", {inReady, outValid, dataAcc}, {2'b10, 32'h30});
    @(negedge clk);
    funcSelect = 4'h3; ar = 16'hFFFF; br = 16'hFFFF; inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    repeat (8) @(negedge clk);
    rstN = 1'b0;
    #1 chk("reset mid-mul", {inReady, outValid, dataAcc}, '0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (outValid) seen++;
    end
    chk("no output after reset", seen, 0);
    v = '{4'hF, 16'h1357, 16'h2468, 32'h0, 0, 1, 0, 1, 1};
    run(v, "invalid after reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
